// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job arbiter.
//   state_e   : controller state encoding (3-bit), also exported on the debug port
//   GCD_WIDTH : default operand/result width of the shared engine
//   clog2     : ceiling log2 (minimum 1) for owner-index and counter widths
package gcd_pkg;

  localparam int GCD_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4,
    CLEAR  = 3'd5
  } state_e;

  // Smallest r with 2**r >= value, never below 1 so a 1-bit field still exists.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Combinational round-robin pick.
//   req_i   : per-requester request bits
//   ptr_i   : highest-priority requester index this round
//   grant_o : one-hot winner (all zero when nobody requests)
//   idx_o   : binary index of the winner
//   any_o   : at least one request present
// Search order is ptr_i, ptr_i+1, ... wrapping N_REQ-1 -> 0.
module gcd_rr_arbiter
  import gcd_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Walk candidates from furthest-from-pointer to the pointer itself; the last
  // hit wins, so the candidate closest to the pointer has priority.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (i == ((int'(ptr_i) + k) % N_REQ) && req_i[i]) begin
          grant_o    = '0;
          grant_o[i] = 1'b1;
          idx_o      = IDX_W'(i);
          any_o      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gcd_job_arbiter.sv
// Shares one unmodified GCD engine among N_REQ requesters.
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/req_a/req_b : job requests, operands packed [i*WIDTH +: WIDTH]
//   req_ready             : one-hot, one-cycle accept pulse
//   rsp_valid/rsp_data/rsp_err/rsp_ready : result to owner, held until owner acks
//   eng_start/eng_data/eng_clr : engine control (A then B loaded under start)
//   eng_done/eng_result   : engine completion level and result
//   dbg_state             : current controller state
//
// Handshake: a job is taken when the arbiter samples req_valid[i]=1 in IDLE;
// req_ready[i] pulses the following cycle and the operands are no longer looked
// at. A response is delivered while rsp_valid[owner]=1 and completes on the
// first clock edge with rsp_ready[owner]=1; other rsp_ready bits are ignored.
//
// All outputs come straight from registers: each _d is the value the output
// must show while the FSM sits in its next state.
module gcd_job_arbiter
  import gcd_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = GCD_WIDTH,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_err,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic                   eng_start,
  output logic [WIDTH-1:0]       eng_data,
  output logic                   eng_clr,
  input  logic                   eng_done,
  input  logic [WIDTH-1:0]       eng_result,
  output state_e                 dbg_state
);

  localparam int IDX_W = clog2(N_REQ);
  localparam int CNT_W = clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  req_ready_q, req_ready_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              eng_start_q, eng_start_d;
  logic [WIDTH-1:0]  eng_data_q, eng_data_d;
  logic              eng_clr_q, eng_clr_d;

  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic [N_REQ-1:0]  owner_oh;

  gcd_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  assign sel_a    = req_a[grant_idx*WIDTH +: WIDTH];
  assign sel_b    = req_b[grant_idx*WIDTH +: WIDTH];
  assign owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    eng_start_d = 1'b0;
    eng_data_d  = eng_data_q;
    eng_clr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          req_ready_d = grant;
          owner_d     = grant_idx;
          b_d         = sel_b;
          ptr_d       = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
          if (sel_a == '0 || sel_b == '0) begin
            // gcd with a zero operand is the other operand; OR covers 0,0 too.
            state_d     = RESP;
            rsp_valid_d = grant;
            rsp_data_d  = sel_a | sel_b;
            rsp_err_d   = 1'b0;
          end else begin
            // A needs no separate latch: it goes straight into eng_data.
            state_d     = LOAD_A;
            eng_start_d = 1'b1;
            eng_data_d  = sel_a;
          end
        end
      end

      LOAD_A: begin
        state_d     = LOAD_B;
        eng_start_d = 1'b1;
        eng_data_d  = b_q;
      end

      LOAD_B: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (eng_done) begin
          state_d     = RESP;
          rsp_valid_d = owner_oh;
          rsp_data_d  = eng_result;
          rsp_err_d   = 1'b0;
        end else if (cnt_q == TIMEOUT_V) begin
          state_d     = RESP;
          rsp_valid_d = owner_oh;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready[owner_q]) begin
          state_d     = CLEAR;
          rsp_valid_d = '0;
          eng_clr_d   = 1'b1;
          cnt_d       = '0;
        end
      end

      CLEAR: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      eng_start_q <= 1'b0;
      eng_data_q  <= '0;
      eng_clr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      eng_start_q <= eng_start_d;
      eng_data_q  <= eng_data_d;
      eng_clr_q   <= eng_clr_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign eng_start = eng_start_q;
  assign eng_data  = eng_data_q;
  assign eng_clr   = eng_clr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Directed bench for gcd_job_arbiter with a behavioural subtract-Euclid engine.
module tb_gcd_job_arbiter;
  import gcd_pkg::*;

  localparam int N_REQ   = 4;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 15;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_a, req_b;
  logic [N_REQ-1:0]       req_ready, rsp_valid, rsp_ready;
  logic [WIDTH-1:0]       rsp_data;
  logic                   rsp_err;
  logic                   eng_start, eng_clr, eng_done;
  logic [WIDTH-1:0]       eng_data, eng_result;
  state_e                 dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  gcd_job_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .eng_start(eng_start), .eng_data(eng_data), .eng_clr(eng_clr),
    .eng_done(eng_done), .eng_result(eng_result), .dbg_state(dbg_state)
  );

  // Engine model: loads A then B on consecutive start cycles, then one
  // subtraction step per cycle; done is a level held until eng_clr.
  logic [WIDTH-1:0] ea, eb;
  logic [1:0]       eload;
  logic             ebusy;
  logic             eng_hang = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eload <= 2'd0; ebusy <= 1'b0; eng_done <= 1'b0; eng_result <= '0;
      ea <= '0; eb <= '0;
    end else if (eng_clr) begin
      eload <= 2'd0; ebusy <= 1'b0; eng_done <= 1'b0;
    end else if (eng_start) begin
      if (eload == 2'd0) begin ea <= eng_data; eload <= 2'd1; end
      else begin eb <= eng_data; eload <= 2'd2; ebusy <= 1'b1; end
    end else if (ebusy && !eng_hang) begin
      if (ea == eb) begin eng_result <= ea; eng_done <= 1'b1; ebusy <= 1'b0; end
      else if (ea > eb) ea <= ea - eb;
      else eb <= eb - ea;
    end
  end

  always @(negedge clk) if (eng_start === 1'b1) start_cnt++;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0; eng_hang = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_job(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[idx*WIDTH +: WIDTH] = a;
    req_b[idx*WIDTH +: WIDTH] = b;
    req_valid[idx] = 1'b1;
  endtask

  task automatic wait_ready(output logic ok, output logic [N_REQ-1:0] seen);
    ok = 1'b0; seen = '0;
    for (int c = 0; c < 64 && !ok; c++) begin
      @(negedge clk);
      if (req_ready !== '0) begin ok = 1'b1; seen = req_ready; end
    end
  endtask

  task automatic wait_rsp(output logic ok, output int cyc);
    ok = 1'b0; cyc = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid !== '0) ok = 1'b1;
    end
  endtask

  task automatic ack(input logic [N_REQ-1:0] mask);
    rsp_ready = mask;
    @(negedge clk);
    rsp_ready = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = '1; req_a = '1; req_b = '1; rsp_ready = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (req_ready !== '0 || rsp_valid !== '0)
      $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b want 0000 0000", req_ready, rsp_valid);
    n_checks++;
    if (rsp_data !== '0 || rsp_err !== 1'b0)
      $display("FAIL reset_rsp: data=%0d err=%b want 0 0", rsp_data, rsp_err);
    n_checks++;
    if (eng_start !== 1'b0 || eng_data !== '0 || eng_clr !== 1'b0)
      $display("FAIL reset_engine: start=%b data=%0d clr=%b want 0 0 0", eng_start, eng_data, eng_clr);
    n_checks++;
    if (dbg_state !== IDLE) $display("FAIL reset_state: state=%0d want %0d", dbg_state, IDLE);
    n_err += (req_ready !== '0 || rsp_valid !== '0) + (rsp_data !== '0 || rsp_err !== 1'b0)
           + (eng_start !== 1'b0 || eng_data !== '0 || eng_clr !== 1'b0) + (dbg_state !== IDLE);
  endtask

  task automatic test_single_job();
    logic ok; logic [N_REQ-1:0] seen; int cyc;
    do_reset();
    set_job(0, 16'd48, 16'd18);
    wait_ready(ok, seen);
    req_valid[0] = 1'b0;
    n_checks++;
    if (!ok || seen !== 4'b0001) begin n_err++; $display("FAIL single_accept: ok=%b ready=%b want 1 0001", ok, seen); end
    n_checks++;
    if (eng_start !== 1'b1 || eng_data !== 16'd48) begin n_err++; $display("FAIL single_load_a: start=%b data=%0d want 1 48", eng_start, eng_data); end
    @(negedge clk);
    n_checks++;
    if (req_ready !== '0) begin n_err++; $display("FAIL single_ready_pulse: ready=%b want 0000", req_ready); end
    n_checks++;
    if (eng_start !== 1'b1 || eng_data !== 16'd18) begin n_err++; $display("FAIL single_load_b: start=%b data=%0d want 1 18", eng_start, eng_data); end
    @(negedge clk);
    n_checks++;
    if (eng_start !== 1'b0 || eng_data !== 16'd18) begin n_err++; $display("FAIL single_wait: start=%b data=%0d want 0 18", eng_start, eng_data); end
    wait_rsp(ok, cyc);
    n_checks++;
    if (!ok || rsp_valid !== 4'b0001 || rsp_data !== 16'd6 || rsp_err !== 1'b0) begin
      n_err++; $display("FAIL single_rsp: ok=%b valid=%b data=%0d err=%b want 1 0001 6 0", ok, rsp_valid, rsp_data, rsp_err);
    end
    ack(4'b0001);
    n_checks++;
    if (eng_clr !== 1'b1 || rsp_valid !== '0) begin n_err++; $display("FAIL single_clr: clr=%b valid=%b want 1 0000", eng_clr, rsp_valid); end
    @(negedge clk);
    n_checks++;
    if (eng_clr !== 1'b0) begin n_err++; $display("FAIL single_clr_pulse: clr=%b want 0", eng_clr); end
  endtask

  task automatic test_round_robin();
    logic ok; logic [N_REQ-1:0] seen; int cyc;
    int exp_idx [5];
    logic [WIDTH-1:0] exp_res [5];
    exp_idx = '{0, 1, 2, 3, 0};
    exp_res = '{16'd4, 16'd3, 16'd7, 16'd1, 16'd4};
    do_reset();
    set_job(0, 16'd12, 16'd8);
    set_job(1, 16'd9, 16'd6);
    set_job(2, 16'd35, 16'd14);
    set_job(3, 16'd17, 16'd5);
    for (int j = 0; j < 5; j++) begin
      wait_ready(ok, seen);
      if (j == 4) req_valid = '0;
      n_checks++;
      if (!ok || seen !== (4'b0001 << exp_idx[j])) begin
        n_err++; $display("FAIL rr_grant%0d: ok=%b ready=%b want owner %0d", j, ok, seen, exp_idx[j]);
      end
      wait_rsp(ok, cyc);
      n_checks++;
      if (!ok || rsp_valid !== (4'b0001 << exp_idx[j]) || rsp_data !== exp_res[j] || rsp_err !== 1'b0) begin
        n_err++; $display("FAIL rr_rsp%0d: valid=%b data=%0d err=%b want owner %0d data %0d err 0", j, rsp_valid, rsp_data, rsp_err, exp_idx[j], exp_res[j]);
      end
      ack(rsp_valid);
    end
  endtask

  task automatic test_zero_bypass();
    logic ok; logic [N_REQ-1:0] seen; int cyc;
    int idx [3];
    logic [WIDTH-1:0] av [3], bv [3], exp_res [3];
    int starts_before;
    idx = '{1, 3, 2};
    av  = '{16'd0, 16'd0, 16'd40};
    bv  = '{16'd25, 16'd0, 16'd0};
    exp_res = '{16'd25, 16'd0, 16'd40};
    do_reset();
    starts_before = start_cnt;
    for (int j = 0; j < 3; j++) begin
      set_job(idx[j], av[j], bv[j]);
      wait_ready(ok, seen);
      req_valid[idx[j]] = 1'b0;
      n_checks++;
      if (!ok || seen !== (4'b0001 << idx[j])) begin
        n_err++; $display("FAIL bypass_accept%0d: ok=%b ready=%b want owner %0d", j, ok, seen, idx[j]);
      end
      // No engine phase: the result is already presented alongside the accept pulse.
      n_checks++;
      if (rsp_valid !== (4'b0001 << idx[j]) || rsp_data !== exp_res[j] || rsp_err !== 1'b0) begin
        n_err++; $display("FAIL bypass_rsp%0d: valid=%b data=%0d err=%b want owner %0d data %0d err 0", j, rsp_valid, rsp_data, rsp_err, idx[j], exp_res[j]);
      end
      ack(4'b0001 << idx[j]);
      n_checks++;
      if (eng_clr !== 1'b1) begin n_err++; $display("FAIL bypass_clr%0d: clr=%b want 1", j, eng_clr); end
    end
    n_checks++;
    if (start_cnt != starts_before) begin n_err++; $display("FAIL bypass_no_start: starts=%0d want %0d", start_cnt, starts_before); end
  endtask

  // Follows test_zero_bypass without reset, so rsp_data starts at 40.
  task automatic test_timeout();
    logic ok; logic [N_REQ-1:0] seen; int cyc;
    eng_hang = 1'b1;
    set_job(2, 16'd9, 16'd6);
    wait_ready(ok, seen);
    req_valid[2] = 1'b0;
    n_checks++;
    if (!ok || seen !== 4'b0100) begin n_err++; $display("FAIL to_accept: ok=%b ready=%b want 1 0100", ok, seen); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (dbg_state !== WAIT) begin n_err++; $display("FAIL to_enter_wait: state=%0d want %0d", dbg_state, WAIT); end
    // Counter is 0 in this first WAIT cycle and reaches TIMEOUT 15 cycles later;
    // the abort response is visible the cycle after that.
    wait_rsp(ok, cyc);
    n_checks++;
    if (!ok || cyc != TIMEOUT + 1 || rsp_valid !== 4'b0100 || rsp_data !== '0 || rsp_err !== 1'b1) begin
      n_err++; $display("FAIL to_rsp: ok=%b cycles=%0d valid=%b data=%0d err=%b want 1 16 0100 0 1", ok, cyc, rsp_valid, rsp_data, rsp_err);
    end
    ack(4'b0100);
    n_checks++;
    if (eng_clr !== 1'b1) begin n_err++; $display("FAIL to_clr: clr=%b want 1", eng_clr); end
    eng_hang = 1'b0;
    set_job(3, 16'd35, 16'd14);
    wait_ready(ok, seen);
    req_valid[3] = 1'b0;
    n_checks++;
    if (!ok || seen !== 4'b1000) begin n_err++; $display("FAIL to_next_accept: ok=%b ready=%b want 1 1000", ok, seen); end
    wait_rsp(ok, cyc);
    n_checks++;
    if (!ok || rsp_valid !== 4'b1000 || rsp_data !== 16'd7 || rsp_err !== 1'b0) begin
      n_err++; $display("FAIL to_next_rsp: valid=%b data=%0d err=%b want 1000 7 0", rsp_valid, rsp_data, rsp_err);
    end
    ack(4'b1000);
  endtask

  task automatic test_hold_ack();
    logic ok; logic [N_REQ-1:0] seen; int cyc;
    do_reset();
    set_job(1, 16'd12, 16'd8);
    wait_ready(ok, seen);
    req_valid[1] = 1'b0;
    wait_rsp(ok, cyc);
    n_checks++;
    if (!ok || rsp_valid !== 4'b0010 || rsp_data !== 16'd4) begin
      n_err++; $display("FAIL hold_rsp: ok=%b valid=%b data=%0d want 1 0010 4", ok, rsp_valid, rsp_data);
    end
    set_job(2, 16'd17, 16'd5);
    for (int c = 0; c < 20; c++) begin
      rsp_ready = '0;
      if (c % 2 == 0) rsp_ready[0] = 1'b1; else rsp_ready[3] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 4'b0010 || rsp_data !== 16'd4 || rsp_err !== 1'b0 || req_ready !== '0 || eng_clr !== 1'b0) begin
        n_err++; $display("FAIL hold_cycle%0d: valid=%b data=%0d err=%b ready=%b clr=%b want 0010 4 0 0000 0", c, rsp_valid, rsp_data, rsp_err, req_ready, eng_clr);
      end
    end
    rsp_ready = '0;
    ack(4'b0010);
    wait_ready(ok, seen);
    req_valid[2] = 1'b0;
    n_checks++;
    if (!ok || seen !== 4'b0100) begin n_err++; $display("FAIL hold_next_grant: ok=%b ready=%b want 1 0100", ok, seen); end
    wait_rsp(ok, cyc);
    n_checks++;
    if (!ok || rsp_valid !== 4'b0100 || rsp_data !== 16'd1) begin
      n_err++; $display("FAIL hold_next_rsp: valid=%b data=%0d want 0100 1", rsp_valid, rsp_data);
    end
    ack(4'b0100);
  endtask

  task automatic test_reset_in_wait();
    logic ok; logic [N_REQ-1:0] seen; int cyc; int stray;
    do_reset();
    set_job(0, 16'd48, 16'd18);
    wait_ready(ok, seen);
    req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (dbg_state !== WAIT || eng_data !== 16'd18) begin
      n_err++; $display("FAIL rstw_in_wait: state=%0d data=%0d want %0d 18", dbg_state, eng_data, WAIT);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (dbg_state !== IDLE || req_ready !== '0 || rsp_valid !== '0 || rsp_data !== '0 || rsp_err !== 1'b0
        || eng_start !== 1'b0 || eng_data !== '0 || eng_clr !== 1'b0) begin
      n_err++; $display("FAIL rstw_async: state=%0d ready=%b valid=%b data=%0d err=%b start=%b edata=%0d clr=%b want all 0",
                        dbg_state, req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_data, eng_clr);
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_valid !== '0) stray++;
    end
    n_checks++;
    if (stray != 0) begin n_err++; $display("FAIL rstw_no_rsp: rsp cycles=%0d want 0", stray); end
    set_job(0, 16'd21, 16'd14);
    wait_ready(ok, seen);
    req_valid[0] = 1'b0;
    n_checks++;
    if (!ok || seen !== 4'b0001) begin n_err++; $display("FAIL rstw_accept: ok=%b ready=%b want 1 0001", ok, seen); end
    wait_rsp(ok, cyc);
    n_checks++;
    if (!ok || rsp_valid !== 4'b0001 || rsp_data !== 16'd7 || rsp_err !== 1'b0) begin
      n_err++; $display("FAIL rstw_rsp: valid=%b data=%0d err=%b want 0001 7 0", rsp_valid, rsp_data, rsp_err);
    end
    ack(4'b0001);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    test_reset();
    test_single_job();
    test_round_robin();
    test_zero_bypass();
    test_timeout();
    test_hold_ack();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gcd_job_arbiter.md
Name: gcd_job_arbiter

Overview:
- Shares one GCD datapath/controller pair (the engine) among N_REQ requesters.
- Round-robin accepts one job (operand pair A,B) at a time and sequences the engine's start / data_in loading: A first, then B.
- Waits for the engine's done, returns the result to the owning requester, then clears the engine for the next job.
- Sits between the requester ports and the engine; the engine itself is unmodified.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 16, operand/result width; matches engine data_in
TIMEOUT, 1023, max WAIT cycles before the job is aborted with an error

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester job request
req_a  in  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
req_b  in  N_REQ*WIDTH  operand B, same packing
req_ready  out  N_REQ  one-hot, one-cycle accept pulse
rsp_valid  out  N_REQ  one-hot, result valid to owner
rsp_data  out  WIDTH  result (shared bus)
rsp_err  out  1  qualifies rsp_data; 1 = timeout abort
rsp_ready  in  N_REQ  owner acknowledge
eng_start  out  1  engine start
eng_data  out  WIDTH  engine data_in
eng_clr  out  1  engine clear/restart pulse
eng_done  in  1  engine done (level, held until cleared)
eng_result  in  WIDTH  engine result register (valid when eng_done=1)

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, eng_start=0, eng_data=0, eng_clr=0; state=IDLE; rr pointer=0; timeout counter=0.
- rst asserted mid-job: aborts immediately to IDLE with all outputs at reset values. No response is issued for the aborted job.
- State IDLE:
  - Grant the first requester with req_valid=1, searching from the rr pointer upward with wrap (N_REQ-1 -> 0).
  - On grant: req_ready[winner]=1 for exactly one cycle; latch A, B and the owner index; pointer <= owner+1 (mod N_REQ).
  - Next state: LOAD_A, or RESP if A==0 or B==0.
  - Zero bypass: gcd(0,x)=x, gcd(x,0)=x, gcd(0,0)=0; rsp_err=0.
- State LOAD_A (1 cycle): eng_start=1, eng_data=A. Next: LOAD_B.
- State LOAD_B (1 cycle): eng_start=1, eng_data=B. Next: WAIT.
- State WAIT:
  - eng_start=0, eng_data held at B; counter increments each cycle.
  - If eng_done=1: latch eng_result into rsp_data, rsp_err=0, go to RESP.
  - Else if counter==TIMEOUT: rsp_data=0, rsp_err=1, go to RESP.
  - eng_done takes priority when both occur in the same cycle.
- State RESP:
  - rsp_valid[owner]=1; rsp_data/rsp_err stable until acknowledged.
  - Exits on rsp_ready[owner]=1 sampled, including in the first RESP cycle. rsp_ready of non-owners is ignored.
  - Next: CLEAR.
- State CLEAR (1 cycle): eng_clr=1, rsp_valid=0, counter=0. Next: IDLE.
- Minimum job-to-job spacing is CLEAR plus one IDLE cycle. Latency from accept to rsp_valid is 3 + engine cycles (bypass: 1).
- req_valid may drop at any time before acceptance; nothing is latched for it. After acceptance, the requester's operands are ignored.
- Fairness: a continuously requesting requester is served within N_REQ jobs.

Decomposition:
- Shared package gcd_pkg:
  - state encoding constants: IDLE, LOAD_A, LOAD_B, WAIT, RESP, CLEAR (3-bit)
  - GCD_WIDTH default 16
  - function clog2 for the owner index and counter widths
- One natural sub-module: gcd_rr_arbiter (combinational round-robin pick from req_valid and pointer; outputs grant one-hot, index and any_req). The FSM, operand latches and counter live in the top.

Test Plan:
- Single job, requester 0, A=48, B=18 with a behavioural engine model:
  - req_ready[0] pulses once.
  - eng_data=48 with eng_start, then 18.
  - rsp_valid[0] with rsp_data=6, rsp_err=0.
  - eng_clr pulses after rsp_ready[0].
- All 4 requesters continuously valid, operands (12,8), (9,6), (35,14), (17,5):
  - grants in order 0,1,2,3,0.
  - results 4, 3, 7, 1, each on the correct rsp_valid bit.
- Zero bypass: (0,25) -> 25, (40,0) -> 40, (0,0) -> 0.
  - eng_start never asserted.
  - rsp_valid one cycle after accept.
- Engine model never raises eng_done, TIMEOUT=15:
  - rsp_err=1, rsp_data=0 exactly 15 cycles into WAIT.
  - eng_clr pulses, then the next job proceeds normally.
- Owner holds rsp_ready low 20 cycles while a non-owner pulses rsp_ready:
  - rsp_valid/rsp_data held stable.
  - no new grant until the owner acks.
- rst asserted during WAIT:
  - all outputs 0 asynchronously, no response issued.
  - after release, a new job (21,14) returns 7.
